// File: rtl/bus_mux_driver_pkg.sv
// Shared definitions for the datapath bus source side.
// Contents:
//   - default widths for the bus mux (data, source count, select, counter)
//   - bus_state_t : control state encoding (IDLE/DRIVE/ERROR)
//   - SRC_*       : named bus source indices, i.e. bit positions in src_out
//                   and word positions in src_data
package bus_mux_driver_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_SRC    = 24;
  localparam int SEL_WIDTH  = 5;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    ERROR = 2'd2
  } bus_state_t;

  // General purpose registers occupy the low sixteen slots.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  // Special registers follow.
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

endpackage

// File: rtl/bus_mux_driver_onehot_encoder.sv
// One-hot to binary encoder for the bus out-enable requests.
// Ports:
//   i_req    in  NUM_SRC    out-enable request bits, one per source
//   o_index  out SEL_WIDTH  index of the set bit (valid when exactly one set)
//   o_zero   out 1          no request bit set
//   o_multi  out 1          two or more request bits set
module onehot_encoder #(
  parameter int NUM_SRC   = 24,
  parameter int SEL_WIDTH = 5
) (
  input  logic [NUM_SRC-1:0]   i_req,
  output logic [SEL_WIDTH-1:0] o_index,
  output logic                 o_zero,
  output logic                 o_multi
);

  // OR-ing the indices of all set bits yields the exact index when only one
  // bit is set; for multi-hot inputs the index is garbage but o_multi flags it.
  always_comb begin
    logic w_seen;
    w_seen  = 1'b0;
    o_index = '0;
    o_multi = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_req[i]) begin
        if (w_seen) o_multi = 1'b1;
        w_seen  = 1'b1;
        o_index = o_index | SEL_WIDTH'(i);
      end
    end
  end

  assign o_zero = ~|i_req;

endmodule

// File: rtl/bus_mux_driver.sv
// Datapath bus source side: selects one bus-attached register onto the
// registered BUS_MUX_OUT according to the one-hot out-enable requests.
// Ports:
//   clock        in   1                    system clock, rising edge
//   clear_n      in   1                    async active-low reset
//   src_data     in   NUM_SRC*DATA_WIDTH   source words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_out      in   NUM_SRC              one-hot out-enable per source
//   req_valid    in   1                    control requests a transfer
//   req_ready    out  1                    request can be accepted (IDLE only)
//   BUS_MUX_OUT  out  DATA_WIDTH           registered bus value
//   bus_valid    out  1                    strobe: BUS_MUX_OUT holds a new transfer
//   bus_sel      out  SEL_WIDTH            index of last accepted source
//   conflict     out  1                    sticky multi-driver flag
//   err_clear    in   1                    clears conflict and leaves ERROR
//   xfer_count   out  CNT_WIDTH            completed transfers, saturating
//
// state | meaning
// IDLE  | ready for a request; accept samples src_out/src_data
// DRIVE | one cycle: new bus word presented, bus_valid high, transfer counted on exit
// ERROR | multi-hot request seen; requests ignored until err_clear
module bus_mux_driver #(
  parameter int DATA_WIDTH = bus_mux_driver_pkg::DATA_WIDTH,
  parameter int NUM_SRC    = bus_mux_driver_pkg::NUM_SRC,
  parameter int SEL_WIDTH  = bus_mux_driver_pkg::SEL_WIDTH,
  parameter int CNT_WIDTH  = bus_mux_driver_pkg::CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_out,
  input  logic                          req_valid,
  output logic                          req_ready,
  output logic [DATA_WIDTH-1:0]         BUS_MUX_OUT,
  output logic                          bus_valid,
  output logic [SEL_WIDTH-1:0]          bus_sel,
  output logic                          conflict,
  input  logic                          err_clear,
  output logic [CNT_WIDTH-1:0]          xfer_count
);

  import bus_mux_driver_pkg::*;

  bus_state_t              r_state;
  bus_state_t              w_next_state;
  logic [DATA_WIDTH-1:0]   r_bus_data;
  logic [SEL_WIDTH-1:0]    r_bus_sel;
  logic                    r_conflict;
  logic [CNT_WIDTH-1:0]    r_count;

  logic [SEL_WIDTH-1:0]    w_index;
  logic                    w_zero;
  logic                    w_multi;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_sel_word;

  onehot_encoder #(
    .NUM_SRC   (NUM_SRC),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_encoder (
    .i_req   (src_out),
    .o_index (w_index),
    .o_zero  (w_zero),
    .o_multi (w_multi)
  );

  // AND-OR mux: an all-zero request naturally selects 0, which is the
  // idle-bus default, and no index outside NUM_SRC is ever addressed.
  always_comb begin
    w_sel_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel_word = w_sel_word |
                   (src_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{src_out[i]}});
    end
  end

  assign w_accept = req_valid && (r_state == IDLE);

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_multi ? ERROR : DRIVE;
      end
      DRIVE:   w_next_state = IDLE;
      ERROR: begin
        if (err_clear) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic; req_ready is gated by clear_n so it reads 0 throughout reset.
  always_comb begin
    req_ready = 1'b0;
    bus_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready = clear_n;
      DRIVE:   bus_valid = 1'b1;
      default: ;
    endcase
  end

  // Bus word, select, conflict flag and transfer counter.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_bus_data <= '0;
      r_bus_sel  <= '0;
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        if (w_multi) begin
          r_conflict <= 1'b1;
        end else begin
          r_bus_data <= w_sel_word;
          r_bus_sel  <= w_index;
        end
      end
      if ((r_state == ERROR) && err_clear) r_conflict <= 1'b0;
      // A transfer counts as complete on the edge that leaves DRIVE.
      if ((r_state == DRIVE) && (r_count != {CNT_WIDTH{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign BUS_MUX_OUT = r_bus_data;
  assign bus_sel     = r_bus_sel;
  assign conflict    = r_conflict;
  assign xfer_count  = r_count;

endmodule

// File: doc/bus_mux_driver.md
Name: bus_mux_driver

Overview:
- Datapath bus source side. Collects the BUS_MUX_IN outputs of every bus-attached register plus the one-hot out-enable requests (R0out..Zlowout, PCout, MDRout, ...) from control.
- Encodes the requests, selects one source, and drives the registered BUS_MUX_OUT that all REGISTER instances load from.
- Detects illegal multi-driver requests and counts completed transfers for debug.

Parameters:
- DATA_WIDTH, 32, width of each source word and of BUS_MUX_OUT
- NUM_SRC, 24, number of bus sources (max 32)
- SEL_WIDTH, 5, encoded source index width, ceil(log2(NUM_SRC))
- CNT_WIDTH, 16, transfer counter width

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- src_data  in  NUM_SRC*DATA_WIDTH  concatenated source words; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_out  in  NUM_SRC  one-hot out-enable request per source
- req_valid  in  1  control requests a bus transfer this cycle
- req_ready  out  1  block can accept a request this cycle
- BUS_MUX_OUT  out  DATA_WIDTH  registered bus value to all register inputs
- bus_valid  out  1  one-cycle strobe: BUS_MUX_OUT holds the new transfer
- bus_sel  out  SEL_WIDTH  encoded index of the last accepted source
- conflict  out  1  sticky: a multi-hot src_out was accepted
- err_clear  in  1  pulse: clears conflict and leaves ERROR
- xfer_count  out  CNT_WIDTH  completed transfers, saturating

Behaviour:
- Reset (clear_n low, async): state IDLE, BUS_MUX_OUT=0, bus_valid=0, bus_sel=0, conflict=0, xfer_count=0, req_ready=0 while clear_n is low.
- States: IDLE, DRIVE, ERROR. req_ready=1 only in IDLE. Output req_ready is combinational from state.
- Accept = rising edge with req_valid=1 and req_ready=1. src_out and src_data are sampled at that edge only.
- Accept with exactly one bit i set: BUS_MUX_OUT<=src_data word i, bus_sel<=i, go to DRIVE.
- Accept with zero bits set: BUS_MUX_OUT<=0, bus_sel<=0, go to DRIVE. This is the idle-bus default and not an error.
- Accept with two or more bits set: BUS_MUX_OUT and bus_sel unchanged, conflict<=1, go to ERROR. No bus_valid and no count increment.
- DRIVE lasts exactly 1 cycle: bus_valid=1, xfer_count increments (saturating at all-ones), then IDLE. Latency is 1 edge from accept to data; bus_valid is high during the cycle after the accept edge. Peak throughput is 1 transfer per 2 cycles.
- BUS_MUX_OUT holds its value indefinitely between transfers. A consumer REGISTER may load it on any later edge.
- ERROR: req_ready=0 and requests are ignored. On an edge with err_clear=1: conflict<=0, go to IDLE. err_clear in IDLE or DRIVE has no effect.
- req_valid=1 in DRIVE or ERROR is not accepted. Control must hold the request until req_ready is seen.
- Source indices >= NUM_SRC do not exist. Unused encoder codes are never produced.
- Reset asserted mid-DRIVE or mid-ERROR returns all outputs to reset values immediately. Any in-flight strobe is lost.

Decomposition:
- Shared package: DATA_WIDTH, SEL_WIDTH constants, state encoding (IDLE=2'd0, DRIVE=2'd1, ERROR=2'd2), and named source index constants (SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C).
- One combinational sub-module, onehot_encoder. Input NUM_SRC bits; outputs index, zero flag, and multi flag. The FSM and registers stay in bus_mux_driver.

Test Plan:
- Reset, then req_valid=1, src_out=1<<3, word3=32'd10. Expect req_ready=0 for 1 cycle, bus_valid=1 for 1 cycle, BUS_MUX_OUT=10, bus_sel=3, xfer_count=1.
- Back-to-back requests for src 5 (32'd20) then src 20 (32'hDEADBEEF), req_valid held high. Accepts are 2 cycles apart, BUS_MUX_OUT=20 then DEADBEEF, xfer_count=2.
- Request src_out=0. Expect BUS_MUX_OUT=0, bus_sel=0, bus_valid pulse, conflict=0.
- Request src_out=(1<<1)|(1<<7) after a transfer of 32'd30. Expect conflict=1, BUS_MUX_OUT stays 30, no bus_valid, req_ready=0 across 5 further requests. After an err_clear pulse: conflict=0, and the next request for src 2 succeeds.
- Assert clear_n low during a DRIVE cycle. Expect BUS_MUX_OUT=0, bus_valid=0, xfer_count=0 before the next clock edge.
- Force xfer_count near saturation (CNT_WIDTH=4, 17 transfers). Expect xfer_count holds at 15.
